// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared encodings for the CPU timebase controller: operating modes, FSM states
// and the divide ratio loaded at reset.
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_STEP = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_HALT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_WAIT = 2'd2,
    ST_STEP_FIRE = 2'd3
  } state_e;

  localparam int unsigned DIV_DEFAULT = 50_000_000;

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Step-button conditioning: 2-flop synchroniser, optional debounce filter
// (CLK_CTRL_DEBOUNCE_EN) and a registered rising-edge pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic evt_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       evt_q, evt_d;
  logic       level;

`ifdef CLK_CTRL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             db_lvl_q, db_lvl_d;

  // Level only follows the synchronised input after DB_CYCLES stable cycles.
  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (sync_q[1] != db_lvl_q) begin
      if (db_cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        db_lvl_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  assign level = db_lvl_q;
`else
  logic db_unused;
  assign db_unused = (DB_CYCLES != 0);
  assign level     = sync_q[1];
`endif

  always_comb begin
    sync_d = {sync_q[0], btn_i};
    prev_d = level;
    evt_d  = level & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      evt_q  <= evt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU timebase controller: HALT/RUN/STEP FSM producing single-cycle clock enables,
// reloadable prescaler and pulse counter. Optional debounce via CLK_CTRL_DEBOUNCE_EN.
module cpu_clk_ctrl #(
  parameter int               DIV_W       = 32,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = cpu_clk_ctrl_pkg::DIV_DEFAULT,
  parameter int               DB_CYCLES   = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             div_ack_o,
  input  logic             step_btn_i,
  output logic             cpu_ce_o,
  output logic [31:0]      tick_cnt_o,
  output logic [1:0]       state_o
);
  import cpu_clk_ctrl_pkg::*;

  // Handshake: div_load_i is a level request sampled every cycle; each sampled
  // cycle loads div_i and produces one div_ack_o pulse in the following cycle.

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;
  logic             ack_q, ack_d;
  logic [31:0]      tick_q, tick_d;
  logic             step_evt;
  logic             run_active;
  mode_e            mode;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (step_btn_i),
    .evt_o (step_evt)
  );

  assign mode = mode_e'(mode_i);

  always_comb begin
    state_d = state_q;
    case (mode)
      MODE_RUN:  state_d = ST_RUN;
      MODE_STEP: begin
        if (state_q == ST_STEP_WAIT) begin
          state_d = step_evt ? ST_STEP_FIRE : ST_STEP_WAIT;
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end
      default:   state_d = ST_HALT;
    endcase
  end

  // Prescaler only advances while staying in RUN; any other cycle clears it.
  always_comb begin
    run_active = (state_q == ST_RUN) && (mode == MODE_RUN);
    div_d      = div_q;
    cnt_d      = '0;
    ack_d      = 1'b0;
    ce_d       = (state_d == ST_STEP_FIRE);
    if (div_load_i) begin
      div_d = div_i;
      ack_d = 1'b1;
    end else if (run_active && (cnt_q == div_q)) begin
      ce_d = 1'b1;
    end else if (run_active) begin
      cnt_d = cnt_q + 1'b1;
    end
    tick_d = tick_q + {31'b0, ce_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HALT;
      div_q   <= DIV_DEFAULT;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      ack_q   <= 1'b0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      ack_q   <= ack_d;
      tick_q  <= tick_d;
    end
  end

  assign cpu_ce_o   = ce_q;
  assign div_ack_o  = ack_q;
  assign tick_cnt_o = tick_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: stimulus pushes expected pulse/ack cycles,
// negedge monitors pop and compare against cpu_ce_o, tick_cnt_o and div_ack_o.
module tb_cpu_clk_ctrl;
  import cpu_clk_ctrl_pkg::*;

  localparam int DB = 8;
`ifdef CLK_CTRL_DEBOUNCE_EN
  localparam int LAT = DB + 4;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode_i = MODE_HALT;
  logic [31:0] div_i = '0;
  logic        div_load_i = 1'b0;
  logic        div_ack_o;
  logic        step_btn_i = 1'b0;
  logic        cpu_ce_o;
  logic [31:0] tick_cnt_o;
  logic [1:0]  state_o;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          last_pulse = 0;
  logic [31:0] tick_exp = '0;
  logic [63:0] exp_q[$];
  int          ack_exp_q[$];

  cpu_clk_ctrl #(.DIV_W(32), .DIV_DEFAULT(32'd50_000_000), .DB_CYCLES(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_i     (mode_i),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .div_ack_o  (div_ack_o),
    .step_btn_i (step_btn_i),
    .cpu_ce_o   (cpu_ce_o),
    .tick_cnt_o (tick_cnt_o),
    .state_o    (state_o)
  );

  // Clock / cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: entries are {cycle, tick value after that pulse}
  always @(negedge clk) begin
    logic [63:0] e;
    while (exp_q.size() != 0 && int'(exp_q[0][63:32]) < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL ce_missed: no pulse at cycle %0d (now %0d), required tick %0h",
               e[63:32], cyc, e[31:0]);
    end
    if (rst_n && cpu_ce_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ce_unexpected: pulse at cycle %0d tick %0h, none required", cyc, tick_cnt_o);
      end else begin
        e = exp_q.pop_front();
        if (e != {32'(cyc), tick_cnt_o}) begin
          errors++;
          $display("FAIL ce_pulse: got cycle %0d tick %0h, required cycle %0d tick %0h",
                   cyc, tick_cnt_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Ack monitor
  always @(negedge clk) begin
    int a;
    if (rst_n && div_ack_o) begin
      checks++;
      if (ack_exp_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: ack at cycle %0d, none required", cyc);
      end else begin
        a = ack_exp_q.pop_front();
        if (a != cyc) begin
          errors++;
          $display("FAIL ack_cycle: got cycle %0d, required cycle %0d", cyc, a);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic next(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step_to(input int c);
    int guard = 0;
    while (cyc < c && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) begin
      checks++;
      errors++;
      $display("FAIL step_to: reached cycle %0d required %0d", cyc, c);
    end
  endtask

  // From HALT: load div, then enter RUN; first pulse div+1 cycles after entry.
  task automatic run_burst(input int div, input int n);
    int c = cyc;
    div_i      = 32'(div);
    div_load_i = 1'b1;
    ack_exp_q.push_back(c + 1);
    next(1);
    div_load_i = 1'b0;
    mode_i     = MODE_RUN;
    for (int k = 1; k <= n; k++) begin
      tick_exp = tick_exp + 32'd1;
      exp_q.push_back({32'(c + 2 + (div + 1) * k), tick_exp});
    end
    last_pulse = c + 2 + (div + 1) * n;
  endtask

  task automatic press(input int hold, input bit expect_pulse);
    int r = cyc;
    step_btn_i = 1'b1;
    if (expect_pulse) begin
      tick_exp = tick_exp + 32'd1;
      exp_q.push_back({32'(r + LAT), tick_exp});
      step_to(r + LAT);
      check("state_fire", {30'b0, state_o}, {30'b0, ST_STEP_FIRE});
      next(1);
      check("state_back_wait", {30'b0, state_o}, {30'b0, ST_STEP_WAIT});
    end
    step_to(r + hold);
    step_btn_i = 1'b0;
    next(25);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks + 1, errors + 1);
    $fatal(1);
  end

  initial begin
    int c;
    next(3);
    check("rst_ce", {31'b0, cpu_ce_o}, 32'd0);
    check("rst_ack", {31'b0, div_ack_o}, 32'd0);
    check("rst_tick", tick_cnt_o, 32'd0);
    check("rst_state", {30'b0, state_o}, 32'd0);
    check("rst_div", dut.div_q, 32'd50_000_000);
    rst_n = 1'b1;
    next(2);

    // 1: div 3 -> pulse every 4 cycles, 10 pulses
    run_burst(3, 10);
    step_to(last_pulse);
    check("tick_after_10", tick_cnt_o, 32'd10);
    mode_i = MODE_HALT;
    next(3);
    check("halt_state", {30'b0, state_o}, {30'b0, ST_HALT});

    // 2: div 0 -> every cycle; HALT stops at once; div 5 re-entry
    run_burst(0, 5);
    step_to(last_pulse);
    mode_i = MODE_HALT;
    next(2);
    check("halt_state2", {30'b0, state_o}, {30'b0, ST_HALT});
    run_burst(5, 2);
    step_to(last_pulse);
    mode_i = MODE_HALT;
    next(3);

    // 4: load on terminal-count cycle suppresses the pulse
    run_burst(7, 1);
    c = last_pulse;
    step_to(c + 7);
    div_i      = 32'd2;
    div_load_i = 1'b1;
    ack_exp_q.push_back(c + 8);
    next(1);
    div_load_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick_exp = tick_exp + 32'd1;
      exp_q.push_back({32'(c + 8 + 3 * k), tick_exp});
    end
    step_to(c + 17);
    mode_i = MODE_HALT;
    next(3);

    // 3: step events; a press in HALT is discarded
    press(20, 1'b0);
    mode_i = MODE_STEP;
    next(1);
    check("step_wait_state", {30'b0, state_o}, {30'b0, ST_STEP_WAIT});
    next(2);
    press(50, 1'b1);
    for (int i = 0; i < 3; i++) press(20, 1'b1);
    check("tick_after_steps", tick_cnt_o, tick_exp);

`ifdef CLK_CTRL_DEBOUNCE_EN
    // 6: short glitch rejected, long press accepted
    step_btn_i = 1'b1;
    next(5);
    step_btn_i = 1'b0;
    next(20);
    press(20, 1'b1);
`endif
    mode_i = MODE_HALT;
    next(3);

    // 5: tick wrap and asynchronous reset mid-RUN
    force dut.tick_q = 32'hFFFF_FFFE;
    next(1);
    release dut.tick_q;
    tick_exp = 32'hFFFF_FFFE;
    next(1);
    check("tick_preload", tick_cnt_o, 32'hFFFF_FFFE);
    run_burst(0, 2);
    step_to(last_pulse);
    check("tick_wrap", tick_cnt_o, 32'd0);
    mode_i = MODE_HALT;
    next(3);
    run_burst(3, 1);
    step_to(last_pulse + 2);
    rst_n  = 1'b0;
    mode_i = MODE_HALT;
    #1;
    check("arst_ce", {31'b0, cpu_ce_o}, 32'd0);
    check("arst_state", {30'b0, state_o}, 32'd0);
    check("arst_tick", tick_cnt_o, 32'd0);
    check("arst_div", dut.div_q, 32'd50_000_000);
    tick_exp = '0;
    next(2);
    rst_n = 1'b1;
    next(10);
    check("post_rst_state", {30'b0, state_o}, 32'd0);

    checks++;
    if (exp_q.size() != 0 || ack_exp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d pulses %0d acks pending, required 0",
               exp_q.size(), ack_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
